// File: rtl/frame_slot_scheduler.sv
// frame_slot_scheduler
//   Derives a one-cycle frame tick from clk_in. On each tick it latches the
//   request vector and grants exclusive update slots to the requesters, one
//   at a time and lowest index first, using a one-hot grant / done handshake.
//   Every register runs on clk_in; no derived clock is created.
//
// Parameters
//   CLK_HZ, FRAME_HZ : tick period DIV = CLK_HZ/FRAME_HZ cycles (minimum 2)
//   N_CLIENTS        : number of requesters (1..8)
//   SLOT_TIMEOUT     : longest grant in cycles (watchdog build only)
//
// Build option
//   SLOT_TIMEOUT_EN  : when defined, a grant with no done is revoked after
//                      SLOT_TIMEOUT cycles and a timeout pulse is raised.
//                      When undefined, grants are held until done.
//
// Ports
//   clk_in      in   system clock
//   reset       in   synchronous, active-high reset
//   enable      in   frame tick generation enable
//   req         in   per-client update request (level, sampled on the tick)
//   done        in   per-client slot complete (level)
//   grant       out  one-hot or zero slot ownership
//   frame_tick  out  one-cycle pulse per frame
//   frame_cnt   out  frame counter, wraps 255 -> 0
//   busy        out  high while a frame sequence is in progress
//   overrun     out  one-cycle pulse, cycle after a tick hit a busy sequence
//   timeout     out  one-cycle pulse when the watchdog revokes a grant
module frame_slot_scheduler #(
    parameter int CLK_HZ       = 100000000,
    parameter int FRAME_HZ     = 30,
    parameter int N_CLIENTS    = 4,
    parameter int SLOT_TIMEOUT = 1024
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_CLIENTS-1:0] req,
    input  logic [N_CLIENTS-1:0] done,
    output logic [N_CLIENTS-1:0] grant,
    output logic                 frame_tick,
    output logic [7:0]           frame_cnt,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout
);

    localparam int DIV_RAW = CLK_HZ / FRAME_HZ;
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int DIV_W   = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

    logic [DIV_W-1:0]     r_div;
    logic [1:0]           r_state;
    logic [N_CLIENTS-1:0] r_pending;
    logic [N_CLIENTS-1:0] r_grant;
    logic [7:0]           r_frame_cnt;
    logic                 r_overrun;
    logic                 w_tick;
    logic [N_CLIENTS-1:0] w_pick;
    logic                 w_done_hit;

    assign w_tick = enable && (r_div == DIV_LAST);

    // Two's-complement trick isolates the lowest set bit: fixed index order.
    assign w_pick = r_pending & (~r_pending + N_CLIENTS'(1));

    // Only the owner's done matters; done from other clients is masked off.
    assign w_done_hit = |(r_grant & done);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_div <= '0;
        end else if (!enable || (r_div == DIV_LAST)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

`ifdef SLOT_TIMEOUT_EN
    localparam int SLOT_W = $clog2(SLOT_TIMEOUT + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_TIMEOUT - 1);

    logic [SLOT_W-1:0] r_slot;
    logic              r_timeout;

    assign timeout = r_timeout;
`else
    logic w_unused_slot_timeout;

    assign w_unused_slot_timeout = (SLOT_TIMEOUT > 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_grant     <= '0;
            r_frame_cnt <= 8'd0;
            r_overrun   <= 1'b0;
`ifdef SLOT_TIMEOUT_EN
            r_slot      <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            // A tick that finds a sequence in flight is reported, then dropped.
            r_overrun <= w_tick && (r_state != ST_IDLE);
`ifdef SLOT_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            if (w_tick) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_pending <= req;
                        r_state   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (r_pending == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_grant   <= w_pick;
                        r_pending <= r_pending & ~w_pick;
                        r_state   <= ST_GRANT;
`ifdef SLOT_TIMEOUT_EN
                        r_slot    <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    // done wins over a simultaneous watchdog expiry.
                    if (w_done_hit) begin
                        r_grant <= '0;
                        r_state <= ST_SCAN;
                    end
`ifdef SLOT_TIMEOUT_EN
                    else if (r_slot == SLOT_LAST) begin
                        r_grant   <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= ST_SCAN;
                    end else begin
                        r_slot <= r_slot + SLOT_W'(1);
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign frame_tick = w_tick;
    assign frame_cnt  = r_frame_cnt;
    assign busy       = (r_state != ST_IDLE);
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_frame_slot_scheduler.sv
module tb_frame_slot_scheduler;

    logic       clk_in;
    logic       reset;
    logic       enable;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic       frame_tick;
    logic [7:0] frame_cnt;
    logic       busy;
    logic       overrun;
    logic       timeout;

    // values applied just after the next rising edge
    logic       n_rst;
    logic       n_en;
    logic [3:0] n_req;
    logic [3:0] n_dn;

    int n_pass;
    int n_tot;

    frame_slot_scheduler #(
        .CLK_HZ       (300),
        .FRAME_HZ     (30),
        .N_CLIENTS    (4),
        .SLOT_TIMEOUT (8)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .enable     (enable),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt),
        .busy       (busy),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        int         n;
        logic       rst;
        logic       en;
        logic [3:0] rq;
        logic [3:0] dn;
        logic [3:0] g;
        logic       tk;
        logic [7:0] cnt;
        logic       bsy;
        logic       ovr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int n, input logic r, input logic e,
                                input logic [3:0] q, input logic [3:0] d,
                                input logic [3:0] g, input logic tk,
                                input logic [7:0] c, input logic b,
                                input logic o);
        vec_t v;
        v.n = n; v.rst = r; v.en = e; v.rq = q; v.dn = d;
        v.g = g; v.tk = tk; v.cnt = c; v.bsy = b; v.ovr = o;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // one clock cycle: inputs change after the edge, outputs read at the falling edge
    task automatic step();
        @(posedge clk_in);
        #1;
        reset  = n_rst;
        enable = n_en;
        req    = n_req;
        done   = n_dn;
        @(negedge clk_in);
    endtask

    task automatic wait_tick(input string nm, input int bound);
        logic found;
        found = 1'b0;
        for (int k = 0; k < bound && !found; k++) begin
            step();
            if (frame_tick === 1'b1) found = 1'b1;
        end
        chk(nm, 32'(found), 32'd1);
    endtask

    initial begin
        int   ticks;
        int   exp_cnt;
        logic wrapped;

        n_pass = 0;
        n_tot  = 0;
        reset  = 1'b1;
        enable = 1'b0;
        req    = 4'b0;
        done   = 4'b0;
        n_rst  = 1'b1;
        n_en   = 1'b0;
        n_req  = 4'b0;
        n_dn   = 4'b0;

        //   n  rst en req      done     grant    tk cnt  bsy ovr
        add(2, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 8'd0, 0, 0); // reset state
        add(9, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 8'd0, 0, 0); // cycle 8
        add(1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 8'd0, 0, 0); // 9: tick
        add(1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 8'd1, 1, 0); // 10: SCAN
        add(1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 8'd1, 0, 0); // 11
        add(8, 0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 8'd1, 0, 0); // 19: tick
        add(1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 8'd2, 1, 0); // 20
        add(9, 0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 8'd2, 0, 0); // 29: tick
        add(1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 8'd3, 1, 0); // 30
        add(9, 0, 1, 4'b1011, 4'b0000, 4'b0000, 1, 8'd3, 0, 0); // 39: tick T
        add(1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 8'd4, 1, 0); // T+1, req dropped
        add(1, 0, 1, 4'b0000, 4'b0000, 4'b0001, 0, 8'd4, 1, 0); // T+2
        add(1, 0, 1, 4'b0000, 4'b0000, 4'b0001, 0, 8'd4, 1, 0); // T+3
        add(1, 0, 1, 4'b0000, 4'b0001, 4'b0001, 0, 8'd4, 1, 0); // T+4 done
        add(1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 8'd4, 1, 0); // T+5
        add(1, 0, 1, 4'b0000, 4'b0000, 4'b0010, 0, 8'd4, 1, 0); // T+6
        add(1, 0, 1, 4'b0000, 4'b0100, 4'b0010, 0, 8'd4, 1, 0); // T+7 stray done
        add(1, 0, 1, 4'b0000, 4'b0010, 4'b0010, 0, 8'd4, 1, 0); // T+8 done
        add(1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 8'd4, 1, 0); // T+9
        add(1, 0, 1, 4'b0000, 4'b0000, 4'b1000, 1, 8'd4, 1, 0); // T+10 busy tick
        add(1, 0, 1, 4'b0000, 4'b0000, 4'b1000, 0, 8'd5, 1, 1); // T+11 overrun
        add(1, 0, 1, 4'b0000, 4'b1000, 4'b1000, 0, 8'd5, 1, 0); // T+12 done
        add(1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 8'd5, 1, 0); // T+13
        add(1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 8'd5, 0, 0); // T+14 idle

        foreach (tbl[i]) begin
            n_rst = tbl[i].rst;
            n_en  = tbl[i].en;
            n_req = tbl[i].rq;
            n_dn  = tbl[i].dn;
            for (int k = 0; k < tbl[i].n; k++) step();
            chk($sformatf("row%0d grant", i),   32'(grant),      32'(tbl[i].g));
            chk($sformatf("row%0d tick", i),    32'(frame_tick), 32'(tbl[i].tk));
            chk($sformatf("row%0d cnt", i),     32'(frame_cnt),  32'(tbl[i].cnt));
            chk($sformatf("row%0d busy", i),    32'(busy),       32'(tbl[i].bsy));
            chk($sformatf("row%0d overrun", i), 32'(overrun),    32'(tbl[i].ovr));
            chk($sformatf("row%0d timeout", i), 32'(timeout),    32'd0);
        end

`ifndef SLOT_TIMEOUT_EN
        // Overrun: grant held past the next tick, that tick is discarded
        n_req = 4'b0001;
        n_dn  = 4'b0000;
        wait_tick("ovr_first_tick", 12);
        step();
        chk("ovr T+1 busy", 32'(busy), 32'd1);
        step();
        chk("ovr T+2 grant", 32'(grant), 32'b0001);
        for (int k = 3; k <= 10; k++) step();
        chk("ovr T+10 tick", 32'(frame_tick), 32'd1);
        chk("ovr T+10 overrun", 32'(overrun), 32'd0);
        chk("ovr T+10 grant", 32'(grant), 32'b0001);
        n_req = 4'b0000;
        step();
        chk("ovr T+11 overrun", 32'(overrun), 32'd1);
        chk("ovr T+11 cnt", 32'(frame_cnt), 32'd7);
        chk("ovr T+11 grant", 32'(grant), 32'b0001);
        step();
        chk("ovr T+12 overrun", 32'(overrun), 32'd0);
        for (int k = 13; k <= 16; k++) step();
        chk("ovr T+16 grant", 32'(grant), 32'b0001);
        chk("ovr T+16 timeout", 32'(timeout), 32'd0);
        n_dn = 4'b0001;
        step();
        chk("ovr T+17 grant", 32'(grant), 32'b0001);
        n_dn = 4'b0000;
        step();
        chk("ovr T+18 grant", 32'(grant), 32'b0000);
        chk("ovr T+18 busy", 32'(busy), 32'd1);
        step();
        chk("ovr T+19 busy", 32'(busy), 32'd0);
`endif

        // Reset mid-grant, with 1-cycle slots while done is already high
        n_rst = 1'b1;
        n_en  = 1'b1;
        n_req = 4'b0100;
        n_dn  = 4'b0100;
        step();
        n_rst = 1'b0;
        for (int c = 0; c <= 51; c++) begin
            n_dn = (c < 45) ? 4'b0100 : 4'b0000;
            step();
            if (c == 11) chk("rst 1cyc slot grant", 32'(grant), 32'b0100);
            if (c == 12) chk("rst 1cyc slot release", 32'(grant), 32'b0000);
            if (c == 51) begin
                chk("rst pre grant", 32'(grant), 32'b0100);
                chk("rst pre cnt", 32'(frame_cnt), 32'd5);
            end
        end
        n_rst = 1'b1;
        n_dn  = 4'b0000;
        n_req = 4'b0010;
        step();
        n_rst = 1'b0;
        step();
        chk("rst post grant", 32'(grant), 32'b0000);
        chk("rst post cnt", 32'(frame_cnt), 32'd0);
        chk("rst post busy", 32'(busy), 32'd0);
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 8) chk("rst no early tick", 32'(frame_tick), 32'd0);
            if (c == 9) chk("rst first tick", 32'(frame_tick), 32'd1);
        end

        // Enable dropped while a grant is outstanding
        n_req = 4'b0000;
        step();
        n_en = 1'b0;
        step();
        chk("en grant", 32'(grant), 32'b0010);
        chk("en tick", 32'(frame_tick), 32'd0);
        step();
        step();
        n_dn = 4'b0010;
        step();
        chk("en grant held", 32'(grant), 32'b0010);
        n_dn = 4'b0000;
        step();
        chk("en grant released", 32'(grant), 32'b0000);
        step();
        chk("en idle", 32'(busy), 32'd0);
        ticks = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (frame_tick === 1'b1) ticks++;
        end
        chk("en no ticks", 32'(ticks), 32'd0);
        chk("en cnt holds", 32'(frame_cnt), 32'd1);
        n_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 8) chk("en restart no tick", 32'(frame_tick), 32'd0);
            if (k == 9) chk("en restart tick", 32'(frame_tick), 32'd1);
        end
        exp_cnt = 2;

        // Frame counter wraps 255 -> 0
        wrapped = 1'b0;
        for (int t = 0; t < 300 && !wrapped; t++) begin
            wait_tick("wrap tick", 12);
            exp_cnt = (exp_cnt + 1) & 255;
            step();
            chk("wrap cnt", 32'(frame_cnt), 32'(exp_cnt));
            if (exp_cnt == 0) wrapped = 1'b1;
        end
        chk("wrap reached", 32'(wrapped), 32'd1);

`ifdef SLOT_TIMEOUT_EN
        // Watchdog: two clients that never signal done
        n_req = 4'b0011;
        n_dn  = 4'b0000;
        wait_tick("wd tick", 12);
        n_req = 4'b0000;
        step();
        for (int k = 2; k <= 9; k++) begin
            step();
            chk("wd grant0", 32'(grant), 32'b0001);
            chk("wd no timeout0", 32'(timeout), 32'd0);
        end
        step();
        chk("wd revoke0", 32'(grant), 32'b0000);
        chk("wd timeout0", 32'(timeout), 32'd1);
        for (int k = 11; k <= 18; k++) begin
            step();
            chk("wd grant1", 32'(grant), 32'b0010);
            chk("wd no timeout1", 32'(timeout), 32'd0);
        end
        step();
        chk("wd revoke1", 32'(grant), 32'b0000);
        chk("wd timeout1", 32'(timeout), 32'd1);
        step();
        chk("wd idle", 32'(busy), 32'd0);
        chk("wd pulse end", 32'(timeout), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
